// File: rtl/rmt_ingress_arb.sv
// Purpose: packet-atomic round-robin merge of S_COUNT AXI-Stream sources into the RMT input (RMT_ARB_PRIO_EN: port 0 strict priority).
// Latency: 1 cycle to arbitrate in IDLE; an accepted beat is on m_axis_* the next cycle when the skid buffer was empty.
// Backpressure: 2-entry skid buffer; s_axis_tready comes from registers only and drops once both entries are full.
module rmt_ingress_arb #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int USER_WIDTH = 8,
    parameter int ID_WIDTH   = $clog2(S_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic [ID_WIDTH-1:0]           m_axis_tid,
    output logic                          busy,
    output logic [ID_WIDTH-1:0]           grant_port
);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic [USER_WIDTH-1:0] user;
        logic                  last;
        logic [ID_WIDTH-1:0]   id;
    } beat_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] grant_q;
    logic [ID_WIDTH-1:0] last_grant_q;
    logic [ID_WIDTH-1:0] winner;
    logic [ID_WIDTH-1:0] rr_idx;
    logic                rr_found;
    int                  rr_sum;
    logic                req_any;

    beat_t               buf_q [2];
    logic                rd_ptr_q, wr_ptr_q;
    logic [1:0]          count_q;
    logic                buf_full;
    logic                push, pop;

    beat_t               in_beat;
    logic                in_vld;

    assign req_any  = |s_axis_tvalid;
    assign buf_full = (count_q == 2'd2);

    // Cyclic search starting one past the last winner.
    always_comb begin
        winner   = last_grant_q;
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_sum   = 0;
        for (int i = 1; i <= S_COUNT; i++) begin
            rr_sum = int'(last_grant_q) + i;
            if (rr_sum >= S_COUNT) begin
                rr_sum = rr_sum - S_COUNT;
            end
            rr_idx = ID_WIDTH'(rr_sum);
            if (!rr_found && s_axis_tvalid[rr_idx]) begin
                winner   = rr_idx;
                rr_found = 1'b1;
            end
        end
`ifdef RMT_ARB_PRIO_EN
        if (s_axis_tvalid[0]) begin
            winner = '0;
        end
`endif
    end

    // Mux the granted source into one beat tagged with its index.
    always_comb begin
        in_beat = '0;
        in_vld  = 1'b0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_q == ID_WIDTH'(i)) begin
                in_beat.data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                in_beat.keep = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                in_beat.user = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
                in_beat.last = s_axis_tlast[i];
                in_vld       = s_axis_tvalid[i];
            end
        end
        in_beat.id = grant_q;
    end

    always_comb begin
        s_axis_tready = '0;
        if (state_q == BUSY && !buf_full) begin
            s_axis_tready[grant_q] = 1'b1;
        end
    end

    assign push = (state_q == BUSY) && in_vld && !buf_full;
    assign pop  = (count_q != 2'd0) && m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A stalled granted source keeps the grant; only its tlast beat releases it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (push && in_beat.last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q      <= '0;
            last_grant_q <= ID_WIDTH'(S_COUNT - 1);
        end else if (state_q == IDLE && req_any) begin
            grant_q      <= winner;
            last_grant_q <= winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= in_beat;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign m_axis_tvalid = (count_q != 2'd0);
    assign m_axis_tdata  = buf_q[rd_ptr_q].data;
    assign m_axis_tkeep  = buf_q[rd_ptr_q].keep;
    assign m_axis_tuser  = buf_q[rd_ptr_q].user;
    assign m_axis_tlast  = buf_q[rd_ptr_q].last;
    assign m_axis_tid    = buf_q[rd_ptr_q].id;

    assign busy       = (state_q == BUSY);
    assign grant_port = grant_q;

endmodule
